// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD DAC output path: slew FSM states, widths, midscale helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spgd_pkg;

  // Slew limiter operating states
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRACK = 2'd1,
    ST_PARK  = 2'd2
  } slew_state_e;

  // Default DAC resolution
  localparam int unsigned DAC_WIDTH_DEF = 14;

  // Width of the update-tick divider counter (covers UPD_DIV up to 65535)
  localparam int unsigned TICK_CNT_W = 16;

  // Width of the clamp event counter
  localparam int unsigned LIMIT_CNT_W = 16;

  // Offset-binary midscale code for a DAC of the given width: only the MSB set.
  // A 14-bit DAC gives 14'h2000, which is the code for a signed zero sample.
  function automatic logic [31:0] dac_midscale(input int unsigned width);
    dac_midscale = 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Update-tick divider: free-running 0..UPD_DIV-1 counter, tick high on the last count.
// Latency: tick is decoded straight from the count register; UPD_DIV=1 ticks every cycle.
// Backpressure: none; counts every clock regardless of downstream state.
module tick_div
  import spgd_pkg::*;
#(
  parameter int unsigned UPD_DIV = 1
) (
  input  logic adc_clk,
  input  logic rst,
  output logic tick
);

  localparam logic [TICK_CNT_W-1:0] LAST_CNT = TICK_CNT_W'(UPD_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt_q;
  logic [TICK_CNT_W-1:0] cnt_d;

  // Tick on the terminal count; with UPD_DIV=1 the count sits at zero and ticks every cycle
  assign tick = (cnt_q == LAST_CNT);

  // Next count: wrap to zero after the terminal count
  always_comb begin
    cnt_d = cnt_q + TICK_CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Count register, cleared by synchronous reset
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_slew_limiter.sv
// Slew-rate limiter between the multiplier stage and the DAC: ramps output toward the latest sample.
// Latency: p_valid at edge k -> target at k -> cur at k+1 -> dac_dat at k+2 (UPD_DIV=1, unclamped).
// Backpressure: none; the newest valid sample simply replaces the target, older ones are dropped.
module dac_slew_limiter
  import spgd_pkg::*;
#(
  parameter int unsigned DAC_WIDTH = DAC_WIDTH_DEF,
  parameter int unsigned MAX_STEP  = 64,
  parameter int unsigned UPD_DIV   = 1
) (
  input  logic                        adc_clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [DAC_WIDTH-1:0] p_in,
  input  logic                        p_valid,
  output logic [DAC_WIDTH-1:0]        dac_dat,
  output logic                        dac_wr,
  output logic                        busy,
  output logic [LIMIT_CNT_W-1:0]      limit_cnt
);

  localparam int unsigned DIFF_W = DAC_WIDTH + 1;

  localparam logic [DAC_WIDTH-1:0] MIDSCALE = DAC_WIDTH'(dac_midscale(DAC_WIDTH));

  // Clamp thresholds in the widened difference domain, and the step in the cur domain
  localparam logic signed [DIFF_W-1:0]    STEP_POS = DIFF_W'(MAX_STEP);
  localparam logic signed [DIFF_W-1:0]    STEP_NEG = -STEP_POS;
  localparam logic signed [DAC_WIDTH-1:0] STEP_CUR = DAC_WIDTH'(MAX_STEP);

  slew_state_e state_q;

  logic signed [DAC_WIDTH-1:0] target_q;
  logic signed [DAC_WIDTH-1:0] target_d;
  logic signed [DAC_WIDTH-1:0] cur_q;
  logic signed [DAC_WIDTH-1:0] cur_d;
  logic signed [DIFF_W-1:0]    diff;

  logic [LIMIT_CNT_W-1:0] limit_q;
  logic [LIMIT_CNT_W-1:0] limit_d;

  logic [DAC_WIDTH-1:0] dac_dat_q;
  logic [DAC_WIDTH-1:0] dac_code;
  logic                 dac_wr_q;
  logic                 busy_q;

  logic tick;
  logic active;
  logic over_pos;
  logic over_neg;
  logic clamp;

  tick_div #(
    .UPD_DIV (UPD_DIV)
  ) u_tick_div (
    .adc_clk (adc_clk),
    .rst     (rst),
    .tick    (tick)
  );

  // Ramping happens in TRACK and in PARK (ramping down to zero before switching off)
  assign active = (state_q != ST_OFF);

  // Sign-extend both operands by one bit so full-scale swings cannot overflow the difference
  assign diff = {target_q[DAC_WIDTH-1], target_q} - {cur_q[DAC_WIDTH-1], cur_q};

  assign over_pos = (diff > STEP_POS);
  assign over_neg = (diff < STEP_NEG);
  assign clamp    = active && tick && (over_pos || over_neg);

  // Offset-binary conversion: flip the sign bit of the two's-complement value
  assign dac_code = {~cur_q[DAC_WIDTH-1], cur_q[DAC_WIDTH-2:0]};

  // Operating-state FSM: park ramps the output back to zero before going idle
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_q <= ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (en) begin
            state_q <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!en) begin
            state_q <= ST_PARK;
          end
        end
        ST_PARK: begin
          if (en) begin
            state_q <= ST_TRACK;
          end else if (cur_q == '0) begin
            state_q <= ST_OFF;
          end
        end
        default: begin
          state_q <= ST_OFF;
        end
      endcase
    end
  end

  // Target selection: only an enabled TRACK state accepts samples; everything else aims at zero
  always_comb begin
    target_d = '0;
    if (state_q == ST_TRACK && en) begin
      target_d = p_valid ? p_in : target_q;
    end
  end

  // Ramp step: land exactly on target when within one step, otherwise move one full step toward it
  always_comb begin
    cur_d = cur_q;
    if (!active) begin
      cur_d = '0;
    end else if (tick) begin
      if (over_pos) begin
        cur_d = cur_q + STEP_CUR;
      end else if (over_neg) begin
        cur_d = cur_q - STEP_CUR;
      end else begin
        cur_d = target_q;
      end
    end
  end

  // Clamp event counter sticks at all-ones instead of wrapping
  always_comb begin
    limit_d = limit_q;
    if (clamp && (limit_q != '1)) begin
      limit_d = limit_q + LIMIT_CNT_W'(1);
    end
  end

  // Datapath registers: target, current value and clamp count
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      target_q <= '0;
      cur_q    <= '0;
      limit_q  <= '0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      limit_q  <= limit_d;
    end
  end

  // Output registers: DAC code one cycle behind cur, write strobe only on a real code change
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      dac_dat_q <= MIDSCALE;
      dac_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dac_dat_q <= dac_code;
      dac_wr_q  <= (dac_code != dac_dat_q);
      busy_q    <= active && (cur_q != target_q);
    end
  end

  assign dac_dat   = dac_dat_q;
  assign dac_wr    = dac_wr_q;
  assign busy      = busy_q;
  assign limit_cnt = limit_q;

endmodule
